// File: rtl/dmem_write_buffer_pkg.sv
// Shared defaults and FSM encoding for the data-cache write buffer.
// Also pulled in by the dcache_system integration.
package dmem_write_buffer_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 32;
  localparam int WB_DW    = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MRD    = 3'd2,
    ST_WR     = 3'd3,
    ST_RDWAIT = 3'd4
  } wb_state_e;

endpackage

// File: rtl/dmem_write_buffer_if.sv
// Cache-side and memory-side signals of the write buffer.
// The slave modport is the buffer's view; master is the cache/memory side.
interface dmem_write_buffer_if
  import dmem_write_buffer_pkg::*;
#(
  parameter int AW = WB_AW,
  parameter int DW = WB_DW
);

  logic          wr_mem;
  logic          rd_mem;
  logic [AW-1:0] addr_mem;
  logic [DW-1:0] wdata;
  logic [DW-1:0] data_out_mem;
  logic          mem_change;
  logic          wb_full;
  logic          wb_empty;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;

  modport slave (
    input  wr_mem, rd_mem, addr_mem, wdata, m_rdata, m_ack,
    output data_out_mem, mem_change, wb_full, wb_empty,
           m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output wr_mem, rd_mem, addr_mem, wdata, m_rdata, m_ack,
    input  data_out_mem, mem_change, wb_full, wb_empty,
           m_req, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/dmem_write_buffer_wb_fifo.sv
// Write-buffer FIFO with a parallel address CAM returning the newest matching entry.
// Enqueue/dequeue take effect at the edge; enqueue while full is dropped (full is the registered count).
module dmem_write_buffer_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_vld,
  input  logic [AW-1:0] enq_addr,
  input  logic [DW-1:0] enq_dat,
  input  logic          deq_vld,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_dat,
  output logic          full,
  output logic          empty,
  input  logic [AW-1:0] lk_addr,
  output logic          hit,
  output logic [DW-1:0] hit_dat
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] idx;
  logic          enq_ok;
  logic          deq_ok;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign enq_ok    = enq_vld && !full;
  assign deq_ok    = deq_vld && !empty;
  assign head_addr = mem_q[head_q].addr;
  assign head_dat  = mem_q[head_q].dat;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_ok) begin
      mem_d[tail_q] = '{addr: enq_addr, dat: enq_dat};
      tail_d        = tail_q + 1'b1;
    end
    if (deq_ok) begin
      head_d = head_q + 1'b1;
    end
    case ({enq_ok, deq_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to newest so the last match wins.
  always_comb begin
    hit     = 1'b0;
    hit_dat = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (mem_q[idx].addr == lk_addr)) begin
        hit     = 1'b1;
        hit_dat = mem_q[idx].dat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Cache write buffer: queues writes, drains in background, serves reads (forward 2 cycles, memory 1 cycle after m_ack).
// Backpressure: wb_full rejects wr_mem; m_req is held with stable address/data until m_ack.
module dmem_write_buffer
  import dmem_write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_write_buffer_if.slave   bus
);

  wb_state_e     state_q, state_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          mem_change_q, mem_change_d;
  logic          deq_vld;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_dat;
  logic          full;
  logic          empty;
  logic          hit;
  logic [DW-1:0] hit_dat;

  dmem_write_buffer_wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_wb_fifo (
    .clk       (clk),
    .rst       (rst),
    .enq_vld   (bus.wr_mem),
    .enq_addr  (bus.addr_mem),
    .enq_dat   (bus.wdata),
    .deq_vld   (deq_vld),
    .head_addr (head_addr),
    .head_dat  (head_dat),
    .full      (full),
    .empty     (empty),
    .lk_addr   (bus.addr_mem),
    .hit       (hit),
    .hit_dat   (hit_dat)
  );

  always_comb begin
    state_d      = state_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    data_out_d   = data_out_q;
    mem_change_d = 1'b0;
    deq_vld      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Reads win over drain; a write in the same cycle still enqueues.
        if (bus.rd_mem) begin
          state_d = ST_LOOKUP;
        end else if (!empty) begin
          state_d   = ST_WR;
          m_req_d   = 1'b1;
          m_we_d    = 1'b1;
          m_addr_d  = head_addr;
          m_wdata_d = head_dat;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          data_out_d   = hit_dat;
          mem_change_d = 1'b1;
          state_d      = ST_RDWAIT;
        end else begin
          state_d  = ST_MRD;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = bus.addr_mem;
        end
      end
      ST_MRD: begin
        if (bus.m_ack) begin
          data_out_d   = bus.m_rdata;
          mem_change_d = 1'b1;
          m_req_d      = 1'b0;
          state_d      = ST_RDWAIT;
        end
      end
      ST_WR: begin
        if (bus.m_ack) begin
          deq_vld = 1'b1;
          m_req_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_RDWAIT: begin
        if (!bus.rd_mem) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      data_out_q   <= '0;
      mem_change_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      data_out_q   <= data_out_d;
      mem_change_q <= mem_change_d;
    end
  end

  assign bus.m_req        = m_req_q;
  assign bus.m_we         = m_we_q;
  assign bus.m_addr       = m_addr_q;
  assign bus.m_wdata      = m_wdata_q;
  assign bus.data_out_mem = data_out_q;
  assign bus.mem_change   = mem_change_q;
  assign bus.wb_full      = full;
  assign bus.wb_empty     = empty;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Scoreboard bench for dmem_write_buffer: queued writes and expected read data are modelled in the bench.
module tb_dmem_write_buffer;
  import dmem_write_buffer_pkg::*;

  localparam int DEPTH = WB_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_write_buffer_if #(.AW(WB_AW), .DW(WB_DW)) bus ();

  dmem_write_buffer #(.DEPTH(DEPTH), .AW(WB_AW), .DW(WB_DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_wq[$];
  logic [31:0] exp_rq[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int ack_cyc  = 0;
  int mc_cyc   = 0;
  int mc_count = 0;
  int mc0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && bus.mem_change) begin
      mc_count++;
      mc_cyc = cyc;
      if (exp_rq.size() == 0) check("unexpected_mem_change", 1, 0);
      else check("rd_data", bus.data_out_mem, exp_rq.pop_front());
    end
  end

  // One cycle of stimulus; updates the model for what the coming edge will do.
  task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic rd, input logic ack, input logic [31:0] rdat);
    logic        acc;
    logic        fwd;
    logic [31:0] fdat;
    acc = wr && (exp_wq.size() < DEPTH);
    if (ack && bus.m_req && bus.m_we) begin
      if (exp_wq.size() == 0) check("unexpected_write", 1, 0);
      else begin
        check("wr_addr", bus.m_addr, exp_wq[0].addr);
        check("wr_data", bus.m_wdata, exp_wq[0].dat);
        void'(exp_wq.pop_front());
      end
    end
    if (ack && bus.m_req && !bus.m_we) begin
      exp_rq.push_back(rdat);
      ack_cyc = cyc;
    end
    if (acc) exp_wq.push_back('{addr: a, dat: d});
    if (rd && !bus.rd_mem) begin
      rise_cyc = cyc;
      fwd      = 1'b0;
      fdat     = '0;
      foreach (exp_wq[i]) begin
        if (exp_wq[i].addr == a) begin
          fwd  = 1'b1;
          fdat = exp_wq[i].dat;
        end
      end
      if (fwd) exp_rq.push_back(fdat);
    end
    bus.wr_mem   = wr;
    bus.addr_mem = a;
    bus.wdata    = d;
    bus.rd_mem   = rd;
    bus.m_ack    = ack;
    bus.m_rdata  = rdat;
    @(posedge clk);
    #1;
    bus.wr_mem = 1'b0;
    bus.m_ack  = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, bus.addr_mem, '0, bus.rd_mem, 1'b0, '0);
  endtask

  task automatic wait_mreq();
    for (int i = 0; i < 20 && !bus.m_req; i++) idle();
    check("m_req_seen", bus.m_req, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_wq.size() != 0 || bus.m_req); i++) begin
      if (bus.m_req && bus.m_we) drive(1'b0, bus.addr_mem, '0, bus.rd_mem, 1'b1, '0);
      else idle();
    end
    check("drain_done", exp_wq.size(), 0);
    check("empty_after_drain", bus.wb_empty, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.wr_mem   = 1'b0;
    bus.rd_mem   = 1'b0;
    bus.addr_mem = '0;
    bus.wdata    = '0;
    bus.m_rdata  = '0;
    bus.m_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_req", bus.m_req, 0);
    check("rst_m_we", bus.m_we, 0);
    check("rst_m_addr", bus.m_addr, 0);
    check("rst_m_wdata", bus.m_wdata, 0);
    check("rst_data_out", bus.data_out_mem, 0);
    check("rst_mem_change", bus.mem_change, 0);
    check("rst_wb_full", bus.wb_full, 0);
    check("rst_wb_empty", bus.wb_empty, 1);
    rst = 1'b1;

    // Reset in the middle of a drain write; a late ack must be ignored.
    drive(1'b1, 32'h100, 32'hDEAD, 1'b0, 1'b0, '0);
    wait_mreq();
    check("t1_m_we", bus.m_we, 1);
    #3 rst = 1'b0;
    #1;
    check("t1_rst_m_req", bus.m_req, 0);
    check("t1_rst_empty", bus.wb_empty, 1);
    exp_wq.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h5555);
    repeat (3) idle();
    check("t1_late_ack_req", bus.m_req, 0);
    check("t1_late_ack_empty", bus.wb_empty, 1);

    // Fill past capacity with memory stalled.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h10 + i, 32'h1000 + i, 1'b0, 1'b0, '0);
      if (i == 3) check("t2_full", bus.wb_full, 1);
    end
    check("t2_full_after_drop", bus.wb_full, 1);
    check("t2_head_addr", bus.m_addr, 32'h10);
    drive(1'b0, '0, '0, 1'b0, 1'b1, '0);
    check("t2_not_full", bus.wb_full, 0);
    check("t2_not_empty", bus.wb_empty, 0);
    drain();

    // Forward the newest of two matching writes.
    drive(1'b1, 32'h20, 32'hAAAA, 1'b0, 1'b0, '0);
    drive(1'b1, 32'h20, 32'hBBBB, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("t3_no_m_req", bus.m_req, 0);
    end
    check("t3_latency", mc_cyc - rise_cyc, 2);
    drive(1'b0, 32'h20, '0, 1'b0, 1'b0, '0);
    drain();

    // Read miss takes priority over the remaining queued write.
    drive(1'b1, 32'h30, 32'h3030, 1'b0, 1'b0, '0);
    drive(1'b1, 32'h34, 32'h3434, 1'b0, 1'b0, '0);
    check("t4_drain_started", bus.m_req, 1);
    drive(1'b0, 32'h40, '0, 1'b1, 1'b1, '0);
    wait_mreq();
    check("t4_m_we", bus.m_we, 0);
    check("t4_m_addr", bus.m_addr, 32'h40);
    check("t4_still_queued", bus.wb_empty, 0);
    drive(1'b0, 32'h40, '0, 1'b1, 1'b1, 32'h1234);
    idle();
    check("t4_latency", mc_cyc - ack_cyc, 1);
    drive(1'b0, 32'h40, '0, 1'b0, 1'b0, '0);
    drain();

    // Enqueue coinciding with a drain ack, below full and at full.
    drive(1'b1, 32'h50, 32'h5050, 1'b0, 1'b0, '0);
    drive(1'b1, 32'h54, 32'h5454, 1'b0, 1'b0, '0);
    drive(1'b1, 32'h58, 32'h5858, 1'b0, 1'b0, '0);
    drive(1'b1, 32'h5C, 32'h5C5C, 1'b0, 1'b1, '0);
    check("t5_not_full", bus.wb_full, 0);
    drive(1'b1, 32'h60, 32'h6060, 1'b0, 1'b0, '0);
    check("t5_full", bus.wb_full, 1);
    drive(1'b1, 32'h64, 32'h6464, 1'b0, 1'b1, '0);
    check("t5_full_rejects", bus.wb_full, 0);
    drain();

    // Held rd_mem gives exactly one completion.
    drive(1'b0, 32'h70, '0, 1'b1, 1'b0, '0);
    wait_mreq();
    check("t6_m_we", bus.m_we, 0);
    mc0 = mc_count;
    drive(1'b0, 32'h70, '0, 1'b1, 1'b1, 32'h7777);
    for (int i = 0; i < 6; i++) begin
      idle();
      check("t6_no_m_req", bus.m_req, 0);
    end
    check("t6_one_pulse", mc_count - mc0, 1);
    drive(1'b0, 32'h70, '0, 1'b0, 1'b0, '0);
    idle();

    check("end_reads_done", exp_rq.size(), 0);
    check("end_writes_done", exp_wq.size(), 0);
    check("end_empty", bus.wb_empty, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
